// File: rtl/addsub_server.sv
// addsub_server: shared digit-serial add/subtract responder serving two clients.
// Parameters: WIDTH operand/result width, DIGIT bits per CALC cycle (WIDTH % DIGIT must be 0).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cN_req_i                     client N request, held until its ready pulse
//   cN_mode_i                    0 = a-b, 1 = a+b
//   cN_a_i, cN_b_i               operands, latched at accept
//   cN_ready_o                   one-cycle result strobe
//   cN_res_o                     registered result, held until that client's next completion
//   busy_o                       high whenever the FSM is not in IDLE
// Macro ADDSUB_RR_EN: round-robin arbitration when defined, fixed priority (client 0 wins) otherwise.
module addsub_server #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             c0_req_i,
    input  logic             c0_mode_i,
    input  logic [WIDTH-1:0] c0_a_i,
    input  logic [WIDTH-1:0] c0_b_i,
    output logic             c0_ready_o,
    output logic [WIDTH-1:0] c0_res_o,
    input  logic             c1_req_i,
    input  logic             c1_mode_i,
    input  logic [WIDTH-1:0] c1_a_i,
    input  logic [WIDTH-1:0] c1_b_i,
    output logic             c1_ready_o,
    output logic [WIDTH-1:0] c1_res_o,
    output logic             busy_o
);
    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("addsub_server: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP, GAP} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, carry_q, c0_rdy_q, c1_rdy_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, c0_res_q, c1_res_q;
    logic [CW-1:0]    cnt_q;
    logic             req_any, sel, accept, last, mode;
    logic [WIDTH-1:0] a_in, b_in, acc_d;
    logic [DIGIT:0]   slice;

    assign req_any = c0_req_i | c1_req_i;

`ifdef ADDSUB_RR_EN
    // The pointer only advances when it actually settled a contention.
    logic ptr_q;
    assign sel = (c0_req_i & c1_req_i) ? ptr_q : c1_req_i;
    always_ff @(posedge clk_i) ptr_q <= rst_i ? 1'b0 : (accept & c0_req_i & c1_req_i) ? ~ptr_q : ptr_q;
`else
    assign sel = ~c0_req_i;
`endif

    // The GAP exit edge may accept, giving the earliest next accept at n+K+2.
    assign accept = req_any & (state_q == IDLE | state_q == GAP);
    assign mode   = sel ? c1_mode_i : c0_mode_i;
    assign a_in   = sel ? c1_a_i : c0_a_i;
    assign b_in   = sel ? c1_b_i : c0_b_i;
    assign last   = cnt_q == CW'(K - 1);
    assign slice  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Slices arrive LSB first and are shifted in from the top of the accumulator.
    assign acc_d  = (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT)) | (acc_q >> DIGIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = req_any ? CALC : IDLE;
            CALC:      state_d = last ? RESP : CALC;
            RESP:      state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q    <= 1'b0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            c0_rdy_q <= 1'b0;
            c1_rdy_q <= 1'b0;
            c0_res_q <= '0;
            c1_res_q <= '0;
        end else begin
            c0_rdy_q <= 1'b0;
            c1_rdy_q <= 1'b0;
            if (accept) begin
                gnt_q   <= sel;
                a_q     <= a_in;
                b_q     <= mode ? b_in : ~b_in;
                carry_q <= ~mode;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == CALC) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= slice[DIGIT];
                acc_q   <= acc_d;
                cnt_q   <= cnt_q + CW'(1);
                if (last && gnt_q) begin
                    c1_res_q <= acc_d;
                    c1_rdy_q <= 1'b1;
                end
                if (last && !gnt_q) begin
                    c0_res_q <= acc_d;
                    c0_rdy_q <= 1'b1;
                end
            end
        end
    end

    assign c0_ready_o = c0_rdy_q;
    assign c1_ready_o = c1_rdy_q;
    assign c0_res_o   = c0_res_q;
    assign c1_res_o   = c1_res_q;
    assign busy_o     = state_q != IDLE;
endmodule
